// File: rtl/tile_shuffler.sv
// Pair-preserving tile layout generator: loads a base layout (each symbol twice),
// then shuffles it with level+1 passes of LFSR-driven swaps, one swap per cycle.
module tile_shuffler #(
    parameter  int NUM_TILES = 16,
    parameter  int ID_W      = 3,
    localparam int IDX_W     = $clog2(NUM_TILES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                level,
    input  logic [15:0]               seed,
    output logic [NUM_TILES*ID_W-1:0] tile_setup,
    output logic                      busy,
    output logic                      done,
    output logic                      valid
);

    typedef enum logic [1:0] {IDLE, LOAD, SWAP, DONE} state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    state_t          state;
    logic [ID_W-1:0] tiles [NUM_TILES];
    logic [15:0]     lfsr;
    logic [15:0]     seed_q;
    logic [1:0]      level_q;
    logic [1:0]      pass;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] j;

    assign j = lfsr[IDX_W-1:0];

    always_comb begin
        tile_setup = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            tile_setup[i*ID_W +: ID_W] = tiles[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= LFSR_INIT;
            seed_q  <= '0;
            level_q <= '0;
            pass    <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            for (int i = 0; i < NUM_TILES; i++) begin
                tiles[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        level_q <= level;
                        seed_q  <= seed;
                        valid   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < NUM_TILES; i++) begin
                        tiles[i] <= ID_W'(i % (NUM_TILES / 2));
                    end
                    lfsr  <= (seed_q == 16'h0000) ? LFSR_INIT : seed_q;
                    idx   <= IDX_W'(NUM_TILES - 1);
                    pass  <= '0;
                    state <= SWAP;
                end
                SWAP: begin
                    // j==idx writes the same value twice, which is the required no-op
                    tiles[idx] <= tiles[j];
                    tiles[j]   <= tiles[idx];
                    lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
                    if (idx != '0) begin
                        idx <= idx - IDX_W'(1);
                    end else if (pass != level_q) begin
                        idx  <= IDX_W'(NUM_TILES - 1);
                        pass <= pass + 2'd1;
                    end else begin
                        done  <= 1'b1;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_shuffler.sv
// Directed bench for tile_shuffler: default, 4-tile and 64-tile instances against a software model.
module tb_tile_shuffler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [1:0]  level = 2'd0;
    logic [15:0] seed = 16'h0000;

    logic [47:0]  ts0;
    logic [3:0]   ts1;
    logic [319:0] ts2;
    logic busy0, done0, valid0, busy1, done1, valid1, busy2, done2, valid2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tile_shuffler dut0 (.clk(clk), .reset(reset), .start(start0), .level(level), .seed(seed),
                        .tile_setup(ts0), .busy(busy0), .done(done0), .valid(valid0));
    tile_shuffler #(.NUM_TILES(4), .ID_W(1)) dut1 (.clk(clk), .reset(reset), .start(start1),
                        .level(level), .seed(seed), .tile_setup(ts1), .busy(busy1),
                        .done(done1), .valid(valid1));
    tile_shuffler #(.NUM_TILES(64), .ID_W(5)) dut2 (.clk(clk), .reset(reset), .start(start2),
                        .level(level), .seed(seed), .tile_setup(ts2), .busy(busy2),
                        .done(done2), .valid(valid2));

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] model(input int n, input int w, input logic [15:0] sd,
                                           input int lvl);
        int t [64];
        int tmp, j;
        logic [15:0] lf;
        logic [319:0] r;
        lf = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int i = 0; i < n; i++) t[i] = i % (n / 2);
        for (int p = 0; p <= lvl; p++) begin
            for (int k = n - 1; k >= 0; k--) begin
                j = int'(lf) & (n - 1);
                tmp = t[k]; t[k] = t[j]; t[j] = tmp;
                lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
            end
        end
        r = '0;
        for (int i = 0; i < n; i++) r = r | (320'(t[i]) << (i * w));
        return r;
    endfunction

    function automatic logic pair_ok(input logic [319:0] v, input int n, input int w);
        int cnt [64];
        int sym;
        for (int s = 0; s < 64; s++) cnt[s] = 0;
        for (int i = 0; i < n; i++) begin
            sym = int'((v >> (i * w)) & ((320'd1 << w) - 320'd1));
            if (sym >= n / 2) return 1'b0;
            cnt[sym]++;
        end
        for (int s = 0; s < n / 2; s++) if (cnt[s] != 2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [319:0] tiles_of(input int w);
        case (w)
            0: return 320'(ts0);
            1: return 320'(ts1);
            default: return ts2;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done2;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
    endfunction

    // Cycle c is observed 1 time unit after edge c-1; the start edge is edge 0.
    task automatic run(input int w, input logic [1:0] lv, input logic [15:0] sd,
                       output int cyc, output int bc, output logic vload);
        level = lv;
        seed  = sd;
        if (w == 0) start0 = 1'b1; else if (w == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        level = lv + 2'd1;
        seed  = ~sd;
        vload = (w == 0) ? valid0 : (w == 1) ? valid1 : valid2;
        cyc = -1;
        bc  = 0;
        for (int c = 1; c < 400; c++) begin
            if (done_of(w)) begin
                cyc = c;
                break;
            end
            if (busy_of(w)) bc++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, bc, ndone, first_done;
        logic vl;
        logic [319:0] ra0, r3, r0b, rs0, rs1;

        #12;
        chk("rst_tiles", 320'(ts0), 320'd0);
        chk("rst_busy", 320'(busy0), 320'd0);
        chk("rst_done", 320'(done0), 320'd0);
        chk("rst_valid", 320'(valid0), 320'd0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", {ts0, busy0, done0, valid0}, 320'd0);

        run(0, 2'd0, 16'h0001, cyc, bc, vl);
        ra0 = 320'(ts0);
        chk("l0_done_cyc", 320'(cyc), 320'd18);
        chk("l0_valid_load", 320'(vl), 320'd0);
        chk("l0_valid", 320'(valid0), 320'd1);
        chk("l0_pairs", 320'(pair_ok(ra0, 16, 3)), 320'd1);
        chk("l0_model", ra0, model(16, 3, 16'h0001, 0));

        run(0, 2'd3, 16'h1234, cyc, bc, vl);
        r3 = 320'(ts0);
        chk("l3_done_cyc", 320'(cyc), 320'd66);
        chk("l3_busy_cnt", 320'(bc), 320'd65);
        chk("l3_valid_load", 320'(vl), 320'd0);
        chk("l3_pairs", 320'(pair_ok(r3, 16, 3)), 320'd1);
        chk("l3_model", r3, model(16, 3, 16'h1234, 3));
        run(0, 2'd0, 16'h1234, cyc, bc, vl);
        r0b = 320'(ts0);
        chk("l0_1234_model", r0b, model(16, 3, 16'h1234, 0));
        chk("l3_differs", 320'(r3 !== r0b), 320'd1);

        run(0, 2'd1, 16'h0000, cyc, bc, vl);
        rs0 = 320'(ts0);
        run(0, 2'd1, 16'hACE1, cyc, bc, vl);
        rs1 = 320'(ts0);
        chk("seed0_eq_ace1", rs0, rs1);
        chk("seed0_model", rs0, model(16, 3, 16'hACE1, 1));
        run(0, 2'd1, 16'h0000, cyc, bc, vl);
        chk("repeat_same", 320'(ts0), rs0);

        // start pulses during SWAP and in the DONE cycle must be ignored
        level = 2'd0; seed = 16'h0001; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        ndone = 0; first_done = -1;
        for (int c = 1; c <= 30; c++) begin
            if (done0) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (c == 19) chk("ign_busy_after", 320'(busy0), 320'd0);
            start0 = (c == 5 || c == 18);
            @(posedge clk); #1;
        end
        start0 = 1'b0;
        chk("ign_ndone", 320'(ndone), 320'd1);
        chk("ign_done_cyc", 320'(first_done), 320'd18);
        chk("ign_model", 320'(ts0), ra0);

        // asynchronous reset in the fifth SWAP cycle
        level = 2'd0; seed = 16'h0001; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_outs", {ts0, busy0, done0, valid0}, 320'd0);
        @(negedge clk) reset = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done0) ndone++;
        end
        chk("mid_rst_nodone", 320'(ndone), 320'd0);
        run(0, 2'd0, 16'h0001, cyc, bc, vl);
        chk("after_rst_cyc", 320'(cyc), 320'd18);
        chk("after_rst_model", 320'(ts0), ra0);

        run(1, 2'd0, 16'h0005, cyc, bc, vl);
        chk("n4_done_cyc", 320'(cyc), 320'd6);
        chk("n4_pairs", 320'(pair_ok(320'(ts1), 4, 1)), 320'd1);
        chk("n4_model", 320'(ts1), model(4, 1, 16'h0005, 0));
        run(2, 2'd0, 16'hBEEF, cyc, bc, vl);
        chk("n64_done_cyc", 320'(cyc), 320'd66);
        chk("n64_pairs", 320'(pair_ok(ts2, 64, 5)), 320'd1);
        chk("n64_model", ts2, model(64, 5, 16'hBEEF, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
